mult_div_unit: RTL



---
 rtl/mult_div_unit_pkg.sv | 26 ++
 rtl/mult_div_unit_md_arith.sv | 74 +++++++
 rtl/mult_div_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state encodings and default latency constants.
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

  // Operation select. Bit 1 picks divide, bit 0 picks unsigned.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// -----------------------------------------------------------------------------
// md_arith
// Purely combinational arithmetic core of the multiply/divide unit.
// Ports:
//   a, b      in  WIDTH  latched operands (dividend / divisor for divides)
//   op        in  2      operation select (md_op_e)
//   hi_res    out WIDTH  upper product half, or remainder
//   lo_res    out WIDTH  lower product half, or quotient
//   div_zero  out 1      divide operation with a zero divisor
// -----------------------------------------------------------------------------
module md_arith
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  md_op_e           op,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res,
  output logic             div_zero
);

  logic               is_signed;
  logic               is_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;

  // NOTE: every signal driven here gets a value on every path (defaults at the
  // top), so no latch can be inferred from this block.
  always_comb begin
    is_signed = ~op[0];
    is_div    = op[1];
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];

    // Multiply: extend both operands to 2*WIDTH (sign or zero) so a single
    // truncated product gives the correct signed or unsigned result.
    a_ext = {{WIDTH{a_neg}}, a};
    b_ext = {{WIDTH{b_neg}}, b};
    prod  = a_ext * b_ext;

    // Divide on magnitudes, then restore signs. The magnitude of MIN_INT is
    // itself as an unsigned value, so MIN_INT / -1 yields quotient MIN_INT and
    // remainder 0 without a special case.
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = is_div & (b == '0);
    // Keep the divider free of a zero divisor; the result is discarded anyway.
    divisor  = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag    = a_mag / divisor;
    r_mag    = a_mag % divisor;
    quot     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem      = a_neg ? -r_mag : r_mag;

    hi_res = prod[2*WIDTH-1:WIDTH];
    lo_res = prod[WIDTH-1:0];
    if (is_div) begin
      hi_res = rem;
      lo_res = quot;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk       in  1      system clock, rising edge
//   reset_n   in  1      synchronous active-low reset
//   start     in  1      one-cycle request to begin an operation
//   md_op     in  2      00 mult, 01 multu, 10 div, 11 divu
//   oprand_a  in  WIDTH  rs value
//   oprand_b  in  WIDTH  rt value
//   hi_we     in  1      mthi write enable
//   lo_we     in  1      mtlo write enable
//   wdata     in  WIDTH  mthi/mtlo data
//   busy      out 1      operation in flight
//   done      out 1      one-cycle pulse in the cycle HI/LO commit
//   hi, lo    out WIDTH  HI / LO registers
// -----------------------------------------------------------------------------
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] oprand_a,
  input  logic [WIDTH-1:0] oprand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  md_op_e           op_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH-1:0] hi_res;
  logic [WIDTH-1:0] lo_res;
  logic             div_zero;

  // Latency for a new operation, chosen by the divide bit of md_op.
  assign cnt_d = md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  // NOTE: the operand latches carry no reset; they are only consumed after a
  // start has loaded them, so resetting them would buy nothing.
  always_ff @(posedge clk) begin
    if (state_q == MD_IDLE && start) begin
      a_q  <= oprand_a;
      b_q  <= oprand_b;
      op_q <= md_op_e'(md_op);
    end
  end

  md_arith #(
    .WIDTH (WIDTH)
  ) u_md_arith (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .hi_res   (hi_res),
    .lo_res   (lo_res),
    .div_zero (div_zero)
  );

  // NOTE: sequential state uses non-blocking assignments only; done_q is
  // defaulted low first and the later assignment in the same block wins,
  // which makes it a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            state_q <= MD_RUN;
            cnt_q   <= cnt_d;
            busy_q  <= 1'b1;
          end else begin
            // mthi/mtlo only land while idle and no start competes.
            if (hi_we) hi_q <= wdata;
            if (lo_we) lo_q <= wdata;
          end
        end
        MD_RUN: begin
          // start, hi_we and lo_we are deliberately ignored here.
          if (cnt_q == CNT_W'(1)) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (!div_zero) begin
              hi_q <= hi_res;
              lo_q <= lo_res;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
